// File: rtl/power_ctrl.sv
// Master power state controller: OFF/ON/LOCKOUT with qualified off-button
// long-press and inactivity timeout, plus shutdown cause reporting.
module power_ctrl #(
    parameter int OFF_HOLD    = 50,
    parameter int IDLE_CYCLES = 1000,
    parameter int WARN_CYCLES = 100,
    parameter int IDLE_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_on,
    input  logic       power_off_signal,
    input  logic       activity,
    output logic       power_state,
    output logic       power_up_pulse,
    output logic       shutdown_pulse,
    output logic [1:0] shutdown_cause,
    output logic       idle_warn
);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ON      = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    localparam logic [5:0]        OFF_HOLD_C = 6'(OFF_HOLD);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] WARN_START = IDLE_W'(IDLE_CYCLES - WARN_CYCLES);

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_IDLE   = 2'b10;

    state_t            state_q, state_d;
    logic [5:0]        off_cnt_q, off_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic              up_q, up_d;
    logic              sd_q, sd_d;
    logic              pwr_q;
    logic              btn_trip, idle_trip;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'h3f) ? v : v + 6'd1;
    endfunction

    assign btn_trip  = power_off_signal && (off_cnt_q >= OFF_HOLD_C);
    assign idle_trip = !activity && (idle_cnt_q == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            off_cnt_q  <= '0;
            idle_cnt_q <= '0;
            cause_q    <= CAUSE_NONE;
            up_q       <= 1'b0;
            sd_q       <= 1'b0;
            pwr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_cnt_q  <= off_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            cause_q    <= cause_d;
            up_q       <= up_d;
            sd_q       <= sd_d;
            pwr_q      <= (state_d == ST_ON);
        end
    end

    always_comb begin
        state_d    = state_q;
        off_cnt_d  = '0;
        idle_cnt_d = '0;
        cause_d    = cause_q;
        up_d       = 1'b0;
        sd_d       = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (power_on) begin
                    state_d = ST_ON;
                    up_d    = 1'b1;
                    cause_d = CAUSE_NONE;
                end
            end
            ST_ON: begin
                off_cnt_d  = power_off_signal ? sat_inc6(off_cnt_q) : 6'd0;
                idle_cnt_d = activity ? '0 : idle_cnt_q + IDLE_W'(1);
                // Button wins over a coincident idle expiry.
                if (btn_trip || idle_trip) begin
                    state_d    = ST_LOCKOUT;
                    sd_d       = 1'b1;
                    cause_d    = btn_trip ? CAUSE_BUTTON : CAUSE_IDLE;
                    off_cnt_d  = '0;
                    idle_cnt_d = '0;
                end
            end
            ST_LOCKOUT: begin
                if (!power_on) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    assign power_state    = pwr_q;
    assign power_up_pulse = up_q;
    assign shutdown_pulse = sd_q;
    assign shutdown_cause = cause_q;
    assign idle_warn      = (state_q == ST_ON) && (idle_cnt_q >= WARN_START);

endmodule

// File: tb/tb_power_ctrl.sv
// Randomized and directed bench for power_ctrl against a consecutive-sample
// behavioural model of the power state rules.
module tb_power_ctrl;

    localparam int OFF_HOLD    = 50;
    localparam int IDLE_CYCLES = 20;
    localparam int WARN_CYCLES = 5;

    logic       clk;
    logic       rst_n;
    logic       power_on;
    logic       power_off_signal;
    logic       activity;
    logic       power_state;
    logic       power_up_pulse;
    logic       shutdown_pulse;
    logic [1:0] shutdown_cause;
    logic       idle_warn;

    power_ctrl #(
        .OFF_HOLD(OFF_HOLD),
        .IDLE_CYCLES(IDLE_CYCLES),
        .WARN_CYCLES(WARN_CYCLES),
        .IDLE_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .power_on(power_on),
        .power_off_signal(power_off_signal),
        .activity(activity),
        .power_state(power_state),
        .power_up_pulse(power_up_pulse),
        .shutdown_pulse(shutdown_pulse),
        .shutdown_cause(shutdown_cause),
        .idle_warn(idle_warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: powered / locked flags and runs of consecutive samples.
    int m_pwr, m_lock, m_offrun, m_idle, m_cause, m_up, m_sd;
    int sd_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pwr = 0; m_lock = 0; m_offrun = 0; m_idle = 0;
        m_cause = 0; m_up = 0; m_sd = 0;
    endtask

    task automatic step();
        m_up = 0;
        m_sd = 0;
        if (m_pwr != 0) begin
            m_offrun = power_off_signal ? m_offrun + 1 : 0;
            m_idle   = activity ? 0 : m_idle + 1;
            if (m_offrun >= OFF_HOLD + 1 || m_idle >= IDLE_CYCLES) begin
                m_cause  = (m_offrun >= OFF_HOLD + 1) ? 1 : 2;
                m_pwr    = 0;
                m_lock   = 1;
                m_sd     = 1;
                m_offrun = 0;
                m_idle   = 0;
            end
        end else if (m_lock != 0) begin
            if (!power_on) m_lock = 0;
        end else if (power_on) begin
            m_pwr = 1; m_up = 1; m_cause = 0; m_offrun = 0; m_idle = 0;
        end
        @(posedge clk);
        #1;
        if (shutdown_pulse) sd_seen++;
        check("power_state", 32'(power_state), 32'(m_pwr));
        check("power_up_pulse", 32'(power_up_pulse), 32'(m_up));
        check("shutdown_pulse", 32'(shutdown_pulse), 32'(m_sd));
        check("shutdown_cause", 32'(shutdown_cause), 32'(m_cause));
        check("idle_warn", 32'(idle_warn),
              32'((m_pwr != 0) && (m_idle >= IDLE_CYCLES - WARN_CYCLES)));
    endtask

    task automatic power_up();
        power_on = 1'b0;
        step();
        power_on = 1'b1;
        step();
        power_on = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        power_on = 1'b0;
        power_off_signal = 1'b0;
        activity = 1'b0;
        sd_seen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_power_state", 32'(power_state), 0);
        check("rst_cause", 32'(shutdown_cause), 0);
        check("rst_warn", 32'(idle_warn), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: one-cycle power_on request
        power_on = 1'b1;
        step();
        check("s1_up", 32'(power_up_pulse), 1);
        power_on = 1'b0;
        step();
        check("s1_up_drop", 32'(power_up_pulse), 0);
        check("s1_state", 32'(power_state), 1);

        // 2: 50 highs is not enough, 51 is
        for (int i = 0; i < 50; i++) begin
            activity = ((i / 3) % 2) == 1;
            power_off_signal = 1'b1;
            step();
        end
        power_off_signal = 1'b0;
        step();
        check("s2_no_shutdown", 32'(power_state), 1);
        sd_seen = 0;
        for (int i = 0; i < 51; i++) begin
            activity = ((i / 3) % 2) == 1;
            power_off_signal = 1'b1;
            step();
        end
        power_off_signal = 1'b0;
        activity = 1'b0;
        check("s2_off", 32'(power_state), 0);
        check("s2_cause", 32'(shutdown_cause), 1);
        step();
        check("s2_pulses", 32'(sd_seen), 1);

        // 3: idle timeout, then activity at edge 18 restarts countdown
        power_up();
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 14) check("s3_warn_lo", 32'(idle_warn), 0);
            if (e == 15) check("s3_warn_hi", 32'(idle_warn), 1);
        end
        check("s3_off", 32'(power_state), 0);
        check("s3_cause", 32'(shutdown_cause), 2);
        power_up();
        for (int e = 1; e <= 20; e++) begin
            activity = (e == 18);
            step();
        end
        activity = 1'b0;
        check("s3b_still_on", 32'(power_state), 1);
        repeat (20) step();
        check("s3b_idle_off", 32'(power_state), 0);

        // 4: button threshold and idle expiry on the same edge
        power_up();
        sd_seen = 0;
        for (int e = 1; e <= 51; e++) begin
            power_off_signal = 1'b1;
            activity = (e == 31) || (e < 31 && (e % 4) == 0);
            step();
        end
        power_off_signal = 1'b0;
        activity = 1'b0;
        check("s4_cause", 32'(shutdown_cause), 1);
        repeat (3) step();
        check("s4_pulses", 32'(sd_seen), 1);

        // 5: shutdown with power_on held, then release and re-request
        power_on = 1'b0;
        step();
        power_on = 1'b1;
        for (int e = 0; e < 24; e++) step();
        check("s5_lockout", 32'(power_state), 0);
        check("s5_cause", 32'(shutdown_cause), 2);
        power_on = 1'b0;
        step();
        power_on = 1'b1;
        step();
        check("s5_repower", 32'(power_state), 1);
        check("s5_cause_clr", 32'(shutdown_cause), 0);
        power_on = 1'b0;

        // 6: async reset mid countdown with idle_warn asserted
        repeat (16) step();
        check("s6_warn", 32'(idle_warn), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("s6_state", 32'(power_state), 0);
        check("s6_warn_clr", 32'(idle_warn), 0);
        check("s6_sd", 32'(shutdown_pulse), 0);
        check("s6_up", 32'(power_up_pulse), 0);
        check("s6_cause", 32'(shutdown_cause), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("s6_off_after", 32'(power_state), 0);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            power_on         = ($urandom_range(0, 99) < 20);
            power_off_signal = ($urandom_range(0, 99) < 97);
            activity         = ($urandom_range(0, 99) < 6);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
